// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alarm_sequencer
// Description : Alarm match/ring/snooze/timeout sequencer with beeping buzzer
//               drive. Optional macro SNOOZE_LIMIT_EN caps honoured snoozes.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_sequencer #(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] timeData,
  input  logic [15:0] alarmData,
  input  logic        enAlarm,
  input  logic        snoozeIn,
  input  logic        stopIn,
  input  logic        oneMinute,
  input  logic        halfSecond,
  output logic        soundAlarm,
  output logic        ringing,
  output logic        snoozing,
  output logic [3:0]  snoozeCount
);

  localparam logic [3:0] c_SNOOZE_MIN = 4'(SNOOZE_MIN);
  localparam logic [3:0] c_RING_TO    = 4'(RING_TIMEOUT_MIN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_min_cnt;
  logic       r_beep;
  logic       r_snooze_prev;
  logic       r_stop_prev;
  logic       r_sound;
  logic       r_ringing;
  logic       r_snoozing;
  logic [3:0] r_snooze_cnt;

  logic       w_match;
  logic       w_snooze_edge;
  logic       w_quit;
  logic       w_snz_ok;
  logic [3:0] w_min_inc;

  assign w_match       = (timeData == alarmData);
  assign w_snooze_edge = snoozeIn & ~r_snooze_prev;
  assign w_quit        = ~enAlarm | (stopIn & ~r_stop_prev);
  assign w_min_inc     = r_min_cnt + 4'd1;

`ifdef SNOOZE_LIMIT_EN
  localparam logic [3:0] c_MAX_SNOOZE = 4'(MAX_SNOOZE);
  assign w_snz_ok = (r_snooze_cnt < c_MAX_SNOOZE);
`else
  assign w_snz_ok = 1'b1;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_min_cnt     <= 4'd0;
      r_beep        <= 1'b1;
      r_snooze_prev <= 1'b0;
      r_stop_prev   <= 1'b0;
      r_sound       <= 1'b0;
      r_ringing     <= 1'b0;
      r_snoozing    <= 1'b0;
      r_snooze_cnt  <= 4'd0;
    end else begin
      r_snooze_prev <= snoozeIn;
      r_stop_prev   <= stopIn;
      case (r_state)
        S_IDLE: begin
          r_sound    <= 1'b0;
          r_ringing  <= 1'b0;
          r_snoozing <= 1'b0;
          if (enAlarm && w_match) begin
            r_state      <= S_RINGING;
            r_min_cnt    <= 4'd0;
            r_beep       <= 1'b1;
            r_snooze_cnt <= 4'd0;
            r_sound      <= 1'b1;
            r_ringing    <= 1'b1;
          end
        end
        S_RINGING: begin
          if (w_quit) begin
            r_state   <= S_DONE;
            r_sound   <= 1'b0;
            r_ringing <= 1'b0;
          end else if (w_snooze_edge && w_snz_ok) begin
            r_state    <= S_SNOOZE;
            r_min_cnt  <= 4'd0;
            r_sound    <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b1;
            if (r_snooze_cnt != 4'hF) r_snooze_cnt <= r_snooze_cnt + 4'd1;
          end else begin
            if (oneMinute) r_min_cnt <= w_min_inc;
            if (oneMinute && (w_min_inc == c_RING_TO)) begin
              r_state   <= S_DONE;
              r_sound   <= 1'b0;
              r_ringing <= 1'b0;
            end else if (halfSecond) begin
              r_beep  <= ~r_beep;
              r_sound <= ~r_beep;
            end
          end
        end
        S_SNOOZE: begin
          if (w_quit) begin
            r_state    <= S_DONE;
            r_snoozing <= 1'b0;
          end else if (oneMinute) begin
            if (w_min_inc == c_SNOOZE_MIN) begin
              r_state    <= S_RINGING;
              r_min_cnt  <= 4'd0;
              r_beep     <= 1'b1;
              r_sound    <= 1'b1;
              r_ringing  <= 1'b1;
              r_snoozing <= 1'b0;
            end else begin
              r_min_cnt <= w_min_inc;
            end
          end
        end
        S_DONE: begin
          // Wait for the alarm minute to pass so the same match cannot re-ring.
          r_sound    <= 1'b0;
          r_ringing  <= 1'b0;
          r_snoozing <= 1'b0;
          if (!w_match) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign soundAlarm  = r_sound;
  assign ringing     = r_ringing;
  assign snoozing    = r_snoozing;
  assign snoozeCount = r_snooze_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_sequencer
// Description : Scoreboard bench for alarm_sequencer with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_sequencer;

  localparam int SN_MIN = 5;
  localparam int RING_TO = 10;
  localparam int MAX_SN = 3;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [15:0] timeData, alarmData;
  logic        enAlarm, snoozeIn, stopIn, oneMinute, halfSecond;
  logic        soundAlarm, ringing, snoozing;
  logic [3:0]  snoozeCount;

  alarm_sequencer #(
    .SNOOZE_MIN(SN_MIN), .RING_TIMEOUT_MIN(RING_TO), .MAX_SNOOZE(MAX_SN)
  ) dut (
    .sysclk(sysclk), .reset(reset), .timeData(timeData), .alarmData(alarmData),
    .enAlarm(enAlarm), .snoozeIn(snoozeIn), .stopIn(stopIn),
    .oneMinute(oneMinute), .halfSecond(halfSecond),
    .soundAlarm(soundAlarm), .ringing(ringing), .snoozing(snoozing),
    .snoozeCount(snoozeCount)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: phase names, elapsed minutes and half-second ticks.
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2, M_DONE = 3;
  int m_phase = M_IDLE, m_mins = 0, m_halves = 0, m_snz = 0;
  bit m_pstop = 0, m_psnz = 0;
  logic [6:0] sb[$];

  task automatic model_step();
    bit stop_e, snz_e, allow, quit;
    logic [6:0] e;
    if (!reset) begin
      m_phase = M_IDLE; m_mins = 0; m_halves = 0; m_snz = 0;
      m_pstop = 0; m_psnz = 0;
    end else begin
      stop_e = stopIn && !m_pstop;
      snz_e  = snoozeIn && !m_psnz;
      m_pstop = stopIn; m_psnz = snoozeIn;
      quit = !enAlarm || stop_e;
`ifdef SNOOZE_LIMIT_EN
      allow = (m_snz < MAX_SN);
`else
      allow = 1;
`endif
      case (m_phase)
        M_IDLE: if (enAlarm && timeData == alarmData) begin
          m_phase = M_RING; m_mins = 0; m_halves = 0; m_snz = 0;
        end
        M_RING: begin
          if (quit) m_phase = M_DONE;
          else if (snz_e && allow) begin
            m_phase = M_SNZ; m_mins = 0;
            m_snz = (m_snz >= 15) ? 15 : m_snz + 1;
          end else begin
            if (oneMinute) begin
              m_mins++;
              if (m_mins == RING_TO) m_phase = M_DONE;
            end
            if (m_phase == M_RING && halfSecond) m_halves++;
          end
        end
        M_SNZ: begin
          if (quit) m_phase = M_DONE;
          else if (oneMinute) begin
            m_mins++;
            if (m_mins == SN_MIN) begin m_phase = M_RING; m_mins = 0; m_halves = 0; end
          end
        end
        default: if (timeData != alarmData) m_phase = M_IDLE;
      endcase
    end
    e = {(m_phase == M_RING) && (m_halves % 2 == 0), m_phase == M_RING,
         m_phase == M_SNZ, 4'(m_snz)};
    sb.push_back(e);
  endtask

  logic [6:0] mon_e;
  always @(posedge sysclk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("scoreboard{snd,ring,snz,cnt}", {25'd0, soundAlarm, ringing, snoozing, snoozeCount},
            {25'd0, mon_e});
    end
  end

  task automatic step();
    model_step();
    @(negedge sysclk);
  endtask

  task automatic minute();
    oneMinute = 1; step(); oneMinute = 0; step();
  endtask

  task automatic half();
    halfSecond = 1; step(); halfSecond = 0; step();
  endtask

  task automatic press_snooze();
    snoozeIn = 1; step(); snoozeIn = 0; step();
  endtask

  task automatic press_stop();
    stopIn = 1; step(); stopIn = 0; step();
  endtask

  initial begin
    reset = 0; enAlarm = 0; snoozeIn = 0; stopIn = 0; oneMinute = 0; halfSecond = 0;
    alarmData = 16'h0730; timeData = 16'h0729;
    #1 check("reset_outputs", {25'd0, soundAlarm, ringing, snoozing, snoozeCount}, 32'd0);
    @(negedge sysclk);
    step(); step();
    reset = 1; step();

    // Trigger and beep
    enAlarm = 1; step(); step();
    timeData = 16'h0730; step(); step();
    repeat (4) half();

    // Snooze then resume after SNOOZE_MIN minutes
    press_snooze();
    repeat (SN_MIN) minute();
    half();

    // Ring timeout, no re-trigger while matching, then leave the minute
    repeat (RING_TO) minute();
    repeat (3) step();
    timeData = 16'h0731; step(); step();

    // Re-trigger, snooze once, resume, then stop+snooze collision
    timeData = 16'h0730; step(); step();
    press_snooze();
    repeat (SN_MIN) minute();
    stopIn = 1; snoozeIn = 1; step(); stopIn = 0; snoozeIn = 0; step();
    timeData = 16'h0731; step();

    // enAlarm drop during SNOOZE
    timeData = 16'h0730; step(); step();
    press_snooze();
    minute();
    enAlarm = 0; step(); enAlarm = 1; step();
    timeData = 16'h0731; step();

    // Asynchronous reset while ringing; persistent match re-triggers
    timeData = 16'h0730; step(); step(); half();
    reset = 0;
    #1 check("async_reset", {25'd0, soundAlarm, ringing, snoozing, snoozeCount}, 32'd0);
    step(); step();
    reset = 1; step(); step();

    // Four snooze presses within one alarm event
    for (int k = 0; k < 3; k++) begin
      press_snooze();
      repeat (SN_MIN) minute();
    end
    press_snooze();
`ifdef SNOOZE_LIMIT_EN
    check("fourth_snooze_ringing", {31'd0, ringing}, 32'd1);
    check("fourth_snooze_count", {28'd0, snoozeCount}, 32'd3);
`else
    check("fourth_snooze_snoozing", {31'd0, snoozing}, 32'd1);
    check("fourth_snooze_count", {28'd0, snoozeCount}, 32'd4);
`endif
    repeat (SN_MIN) minute();
    press_stop();
    timeData = 16'h0731; step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) timeData = (timeData == alarmData) ? 16'(($urandom & 16'h3FFF) | 16'h8000) : alarmData;
      if ($urandom_range(0, 39) == 0) enAlarm = ~enAlarm;
      if ($urandom_range(0, 7) == 0) snoozeIn = ~snoozeIn;
      if ($urandom_range(0, 19) == 0) stopIn = ~stopIn;
      oneMinute  = ($urandom_range(0, 2) == 0);
      halfSecond = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1; oneMinute = 0; halfSecond = 0; snoozeIn = 0; stopIn = 0;
    step(); step();
    @(posedge sysclk); #2;
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Controls the alarm-sounding side of the digital clock datapath: compares the running time against the alarm register, then sequences ringing, snooze, ring timeout and stop.
- Sits between time_count/alarmReg (time and alarm BCD words), pulsegen (oneMinute/halfSecond ticks) and the display/buzzer driver.
- Produces a gated, beeping soundAlarm plus status flags.

Parameters:
- SNOOZE_MIN, 5: minutes spent in SNOOZE before ringing resumes (1..15).
- RING_TIMEOUT_MIN, 10: minutes of continuous RINGING before auto-stop (1..15).
- MAX_SNOOZE, 3: snooze presses honoured per alarm event; used only with SNOOZE_LIMIT_EN.

Ports:
- sysclk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- timeData  in  16  current time, BCD {H10,H1,M10,M1}.
- alarmData  in  16  alarm time, same format.
- enAlarm  in  1  alarm enable (level).
- snoozeIn  in  1  snooze button (level, synchronous to sysclk).
- stopIn  in  1  stop button (level, synchronous to sysclk).
- oneMinute  in  1  single-cycle pulse, once per minute.
- halfSecond  in  1  single-cycle pulse, every half second.
- soundAlarm  out  1  buzzer drive, beeping.
- ringing  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- snoozeCount  out  4  snoozes taken this event, saturates at 15.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; soundAlarm=0, ringing=0, snoozing=0, snoozeCount=0; minute counter=0; beep phase=1; button edge registers=0.
- match = (timeData == alarmData). It is combinational and is sampled each sysclk edge.
- Buttons: a rising edge is detected internally (prev-value register). A held button acts once only.
- States: IDLE, RINGING, SNOOZE, DONE. All outputs are registered and update on the same edge as the state.
- IDLE: if enAlarm && match, go to RINGING. minCnt=0, beep=1, snoozeCount=0.
- RINGING:
  - stop edge, or enAlarm=0: go to DONE.
  - Else snooze edge (and limit not reached): go to SNOOZE, minCnt=0, snoozeCount+1.
  - Else oneMinute: minCnt+1. When minCnt reaches RING_TIMEOUT_MIN, go to DONE.
  - halfSecond toggles beep.
  - soundAlarm = beep. It is 1 on the entry edge.
- SNOOZE:
  - soundAlarm=0.
  - stop edge, or enAlarm=0: go to DONE.
  - Else oneMinute: minCnt+1. When minCnt reaches SNOOZE_MIN, go to RINGING, minCnt=0, beep=1.
  - Snooze edges are ignored in SNOOZE.
- DONE: soundAlarm=0. When match=0, go to IDLE. This blocks re-triggering within the same alarm minute. snoozeCount holds its value until the next trigger.
- Priority when events coincide on one edge: reset > enAlarm=0 > stop > snooze > oneMinute > halfSecond.
  - A button edge that coincides with oneMinute restarts minCnt at 0. It is not 1.
- Latency: stimulus at edge N is reflected on outputs at edge N+1 (one registered stage).
- Reset mid-operation: immediate return to reset values. A match still present after reset release re-triggers RINGING.
- Counter widths: minCnt is 4 bits. Parameters are limited to 15.

Optional Feature:
- Macro: SNOOZE_LIMIT_EN.
- Defined: a snooze edge in RINGING is honoured only while snoozeCount < MAX_SNOOZE. Beyond that the press is ignored and ringing continues; stop and timeout still apply.
- Undefined: snoozes are unlimited. snoozeCount still counts and saturates at 15. MAX_SNOOZE has no effect.

Test Plan:
- Reset check, then IDLE trigger:
  - Stimulus: reset low, then high; alarmData=0x0730, timeData steps 0x0729 to 0x0730, enAlarm=1.
  - Response: ringing=1 and soundAlarm=1 one edge after the match; soundAlarm toggles on each halfSecond.
- Snooze then resume: while RINGING, snoozeIn pulse.
  - Response: snoozing=1, soundAlarm=0, snoozeCount=1.
  - After 5 oneMinute pulses: ringing=1, soundAlarm=1.
- Timeout and no re-trigger: ring with no buttons for 10 oneMinute pulses.
  - Response: DONE, soundAlarm=0. Holding timeData=0x0730 does not re-ring.
  - Changing timeData to 0x0731 returns to IDLE.
- Stop vs snooze collision: stopIn and snoozeIn rise on the same edge.
  - Response: DONE, snoozeCount unchanged.
- enAlarm drop and reset mid-operation:
  - enAlarm=0 during SNOOZE gives DONE next edge.
  - reset=0 asynchronously during RINGING clears all outputs within the same cycle.
- SNOOZE_LIMIT_EN defined, MAX_SNOOZE=3: fourth snooze press in RINGING is ignored (ringing stays 1, snoozeCount=3). With the macro undefined, the same press gives SNOOZE and snoozeCount=4.
